dunc16_mem_resp: RTL and testbench

DUNC16_MEM_RESP -- requirements
Module: dunc16_mem_resp

---
 rtl/dunc16_mem_resp.sv | 155 +++++++++++++++
 tb/tb_dunc16_mem_resp.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dunc16_mem_resp.sv
// dunc16_mem_resp: single-port 16-bit memory responder with programmable wait
// states. A request is latched in IDLE, then held off for WAIT_STATES cycles.
// The RAM is accessed for one cycle, and the result is returned with a
// one-cycle ACK.
module dunc16_mem_resp #(
  parameter int WAIT_STATES = 2,
  parameter int DEPTH_LOG2  = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        WE,
  input  logic [15:0] ADDRESS,
  input  logic [15:0] WDATA,
  output logic [15:0] RDATA,
  output logic        ACK,
  output logic        ERR,
  output logic        BUSY,
  output logic [15:0] XFER_CNT
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // The counter is loaded with WAIT_STATES-1 and WAIT exits when it reads zero,
  // which gives exactly WAIT_STATES cycles in WAIT.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        busy_reg, ack_reg, err_reg;
  logic        we_reg;
  logic [15:0] addr_reg, wdata_reg;
  logic [15:0] rdata_reg, xfer_cnt_reg;
  logic        accept;
  logic        in_range;

  logic [15:0]           mem [DEPTH];
  logic [15:0]           ram_q;
  logic [DEPTH_LOG2-1:0] ram_raddr;

  assign accept   = (state_reg == ST_IDLE) && REQ;
  assign in_range = (addr_reg >> DEPTH_LOG2) == 16'd0;

  // In IDLE, the RAM read address follows the live ADDRESS input. This lets the
  // registered read data be ready in ACCESS even when there are no wait states.
  // After acceptance, the read address comes from the latched address.
  assign ram_raddr = (state_reg == ST_IDLE) ? ADDRESS[DEPTH_LOG2-1:0]
                                            : addr_reg[DEPTH_LOG2-1:0];

  // Next-state logic: IDLE -> (WAIT) -> ACCESS -> RESP -> IDLE.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (REQ) begin
          if (WAIT_STATES > 0) begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_LOAD;
          end else begin
            state_next = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          state_next = ST_ACCESS;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register. BUSY and ACK are registered alongside the state, so they
  // never depend combinationally on the inputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg    <= ST_IDLE;
      wait_cnt_reg <= 4'd0;
      busy_reg     <= 1'b0;
      ack_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      busy_reg     <= (state_next != ST_IDLE);
      ack_reg      <= (state_next == ST_RESP);
    end
  end

  // Capture the request at acceptance. Later input changes cannot disturb the
  // transaction in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      we_reg    <= 1'b0;
      addr_reg  <= 16'd0;
      wdata_reg <= 16'd0;
    end else if (accept) begin
      we_reg    <= WE;
      addr_reg  <= ADDRESS;
      wdata_reg <= WDATA;
    end
  end

  // Response data is produced at the ACCESS edge and held until the next ACK.
  // ERR is cleared as RESP is left. The transfer counter also steps at that edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rdata_reg    <= 16'd0;
      err_reg      <= 1'b0;
      xfer_cnt_reg <= 16'd0;
    end else begin
      if (state_reg == ST_ACCESS) begin
        err_reg <= !in_range;
        if (!in_range) begin
          rdata_reg <= 16'd0;
        end else if (we_reg) begin
          rdata_reg <= wdata_reg;
        end else begin
          rdata_reg <= ram_q;
        end
      end
      if (state_reg == ST_RESP) begin
        err_reg      <= 1'b0;
        xfer_cnt_reg <= xfer_cnt_reg + 16'd1;
      end
    end
  end

  // Block RAM with a registered read and no reset, so its contents survive
  // RESET. While RESET is low the state is held in IDLE, which blocks any
  // pending write.
  always_ff @(posedge CLK) begin
    if ((state_reg == ST_ACCESS) && we_reg && in_range) begin
      mem[addr_reg[DEPTH_LOG2-1:0]] <= wdata_reg;
    end
    ram_q <= mem[ram_raddr];
  end

  assign RDATA    = rdata_reg;
  assign ACK      = ack_reg;
  assign ERR      = err_reg;
  assign BUSY     = busy_reg;
  assign XFER_CNT = xfer_cnt_reg;

endmodule

// File: tb/tb_dunc16_mem_resp.sv
// Testbench for dunc16_mem_resp. A transaction-level model predicts ACK, BUSY,
// ERR, RDATA and XFER_CNT every cycle for the WAIT_STATES=2 instance. Directed
// transactions pin latency and data with literal values, and a second instance
// with WAIT_STATES=0 checks the short latency.
`timescale 1ns/1ps
module tb_dunc16_mem_resp;

  localparam int W = 2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        REQ = 1'b0;
  logic        REQ0 = 1'b0;
  logic        WE = 1'b0;
  logic [15:0] ADDRESS = 16'd0;
  logic [15:0] WDATA = 16'd0;
  logic [15:0] RDATA, RDATA0, XFER_CNT, XFER_CNT0;
  logic        ACK, ERR, BUSY, ACK0, ERR0, BUSY0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_ack    = 0;

  dunc16_mem_resp #(.WAIT_STATES(W), .DEPTH_LOG2(8)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDRESS(ADDRESS), .WDATA(WDATA),
    .RDATA(RDATA), .ACK(ACK), .ERR(ERR), .BUSY(BUSY), .XFER_CNT(XFER_CNT)
  );

  dunc16_mem_resp #(.WAIT_STATES(0), .DEPTH_LOG2(8)) dut0 (
    .CLK(CLK), .RESET(RESET), .REQ(REQ0), .WE(WE), .ADDRESS(ADDRESS), .WDATA(WDATA),
    .RDATA(RDATA0), .ACK(ACK0), .ERR(ERR0), .BUSY(BUSY0), .XFER_CNT(XFER_CNT0)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // The model works from an edge schedule. A request taken at edge A completes
  // its access at edge A+W+1, which starts the ACK cycle. The following edge ends
  // the ACK cycle and counts the transfer.
  int          m_edge = 0;
  int          m_resp_edge = 0;
  bit          m_busy = 1'b0;
  bit          m_we = 1'b0;
  logic [15:0] m_addr = 16'd0;
  logic [15:0] m_wd = 16'd0;
  logic [15:0] m_mem [256];
  bit          e_ack = 1'b0;
  bit          e_err = 1'b0;
  logic [15:0] e_rdata = 16'd0;
  logic [15:0] e_cnt = 16'd0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_busy  = 1'b0;
      e_ack   = 1'b0;
      e_err   = 1'b0;
      e_rdata = 16'd0;
      e_cnt   = 16'd0;
    end else begin
      m_edge++;
      if (e_ack) begin
        e_ack  = 1'b0;
        e_cnt  = e_cnt + 16'd1;
        m_busy = 1'b0;
      end else if (!m_busy && REQ) begin
        m_busy      = 1'b1;
        m_we        = WE;
        m_addr      = ADDRESS;
        m_wd        = WDATA;
        m_resp_edge = m_edge + W + 1;
      end else if (m_busy && m_edge == m_resp_edge) begin
        e_ack = 1'b1;
        if (m_addr >= 16'd256) begin
          e_err   = 1'b1;
          e_rdata = 16'd0;
        end else if (m_we) begin
          e_err            = 1'b0;
          m_mem[m_addr[7:0]] = m_wd;
          e_rdata          = m_wd;
        end else begin
          e_err   = 1'b0;
          e_rdata = m_mem[m_addr[7:0]];
        end
      end
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge CLK) begin
    chk("ack", {31'd0, ACK}, {31'd0, e_ack});
    chk("busy", {31'd0, BUSY}, {31'd0, m_busy});
    chk("xfer_cnt", {16'd0, XFER_CNT}, {16'd0, e_cnt});
    chk("rdata", {16'd0, RDATA}, {16'd0, e_rdata});
    if (e_ack) chk("err", {31'd0, ERR}, {31'd0, e_err});
    if (ACK) n_ack++;
  end

  // One transaction on the selected instance (sel=1 selects the no-wait one).
  // Once the request is accepted, the inputs are scrambled. lat is the number of
  // edges after the acceptance edge at which ACK is seen.
  task automatic txn(input bit sel, input logic we, input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output logic er, output int lat);
    int acc;
    bit got;
    @(negedge CLK);
    if (sel) REQ0 = 1'b1; else REQ = 1'b1;
    WE = we; ADDRESS = a; WDATA = d;
    @(posedge CLK);
    #1 acc = cyc;
    @(negedge CLK);
    REQ = 1'b0; REQ0 = 1'b0;
    WE = ~we; ADDRESS = ~a; WDATA = ~d;
    got = 1'b0; lat = -1; rd = 16'd0; er = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if ((sel ? ACK0 : ACK) === 1'b1) begin
        got = 1'b1;
        lat = cyc - acc;
        rd  = sel ? RDATA0 : RDATA;
        er  = sel ? ERR0 : ERR;
      end else begin
        @(negedge CLK);
      end
    end
    if (!got) chk("txn_timeout", 32'd0, 32'd1);
    $display("txn sel=%0d we=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d", sel, we, a, d, rd, er, lat);
  endtask

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          k0;

    // Reset state, with RESET held low from time 0.
    #12;
    chk("rst_rdata", {16'd0, RDATA}, 32'h0);
    chk("rst_ack", {31'd0, ACK}, 32'h0);
    chk("rst_err", {31'd0, ERR}, 32'h0);
    chk("rst_busy", {31'd0, BUSY}, 32'h0);
    chk("rst_cnt", {16'd0, XFER_CNT}, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;

    // Write then read 0x0012. The acceptance edge is the first of four edges,
    // so ACK appears 3 edges after it.
    txn(0, 1'b1, 16'h0012, 16'hBEEF, rd, er, lat);
    chk("wr_lat", lat, 32'd3);
    chk("wr_echo", {16'd0, rd}, 32'h0000BEEF);
    txn(0, 1'b0, 16'h0012, 16'h0000, rd, er, lat);
    chk("rd_lat", lat, 32'd3);
    chk("rd_data", {16'd0, rd}, 32'h0000BEEF);
    chk("rd_err", {31'd0, er}, 32'h0);
    @(negedge CLK);
    chk("cnt_two", {16'd0, XFER_CNT}, 32'd2);

    // No-wait instance: ACK on the second edge counting the acceptance edge.
    txn(1, 1'b1, 16'h0012, 16'hBEEF, rd, er, lat);
    txn(1, 1'b0, 16'h0012, 16'h0000, rd, er, lat);
    chk("w0_lat", lat, 32'd1);
    chk("w0_data", {16'd0, rd}, 32'h0000BEEF);

    // Range boundaries: the last in-range word, out-of-range write and read.
    txn(0, 1'b1, 16'h0000, 16'h1111, rd, er, lat);
    txn(0, 1'b1, 16'h00FF, 16'h7E7E, rd, er, lat);
    txn(0, 1'b1, 16'h0100, 16'hDEAD, rd, er, lat);
    chk("oor_wr_err", {31'd0, er}, 32'h1);
    chk("oor_wr_rdata", {16'd0, rd}, 32'h0);
    txn(0, 1'b0, 16'hFFFF, 16'h0000, rd, er, lat);
    chk("oor_rd_err", {31'd0, er}, 32'h1);
    chk("oor_rd_rdata", {16'd0, rd}, 32'h0);
    txn(0, 1'b0, 16'h0000, 16'h0000, rd, er, lat);
    chk("addr0_unchanged", {16'd0, rd}, 32'h00001111);
    txn(0, 1'b0, 16'h00FF, 16'h0000, rd, er, lat);
    chk("addr_ff", {16'd0, rd}, 32'h00007E7E);

    // REQ held for 20 edges with the address stepping each cycle. Acceptances
    // land on edges 0, 5, 10 and 15, so four writes complete.
    #1 k0 = n_ack;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      REQ = 1'b1; WE = 1'b1;
      ADDRESS = 16'h0040 + 16'(i);
      WDATA   = 16'hA000 + 16'(i);
    end
    @(negedge CLK);
    REQ = 1'b0;
    repeat (8) @(negedge CLK);
    #1 chk("stream_acks", n_ack - k0, 32'd4);
    $display("stream: %0d acks", n_ack - k0);
    txn(0, 1'b0, 16'h0040, 16'h0000, rd, er, lat);
    chk("stream_a40", {16'd0, rd}, 32'h0000A000);
    txn(0, 1'b0, 16'h0045, 16'h0000, rd, er, lat);
    chk("stream_a45", {16'd0, rd}, 32'h0000A005);
    txn(0, 1'b0, 16'h004F, 16'h0000, rd, er, lat);
    chk("stream_a4f", {16'd0, rd}, 32'h0000A00F);

    // Assert RESET in the middle of WAIT for a write that is then dropped.
    txn(0, 1'b1, 16'h0005, 16'h5555, rd, er, lat);
    @(negedge CLK);
    REQ = 1'b1; WE = 1'b1; ADDRESS = 16'h0005; WDATA = 16'h1234;
    @(posedge CLK);
    #2 REQ = 1'b0;
    @(posedge CLK);
    #2 RESET = 1'b0;
    #1;
    chk("arst_busy", {31'd0, BUSY}, 32'h0);
    chk("arst_ack", {31'd0, ACK}, 32'h0);
    chk("arst_err", {31'd0, ERR}, 32'h0);
    chk("arst_rdata", {16'd0, RDATA}, 32'h0);
    chk("arst_cnt", {16'd0, XFER_CNT}, 32'h0);
    $display("async reset applied mid-wait");
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    txn(0, 1'b0, 16'h0005, 16'h0000, rd, er, lat);
    chk("post_rst_lat", lat, 32'd3);
    chk("post_rst_data", {16'd0, rd}, 32'h00005555);

    // Load XFER_CNT with FFFF, then complete one read: the counter must wrap to 0.
    @(negedge CLK);
    #2;
    force dut.xfer_cnt_reg = 16'hFFFF;
    e_cnt = 16'hFFFF;
    #1 release dut.xfer_cnt_reg;
    txn(0, 1'b0, 16'h0012, 16'h0000, rd, er, lat);
    chk("wrap_data", {16'd0, rd}, 32'h0000BEEF);
    @(negedge CLK);
    #1 chk("wrap_cnt", {16'd0, XFER_CNT}, 32'h0);

    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
